md_div_seq: RTL
===============

MD_DIV_SEQ -- requirements
Module: md_div_seq

Interface
REQ-001 SHALL have parameter: XLEN, 64, operand/result width; only 64 is supported.
REQ-002 SHALL have port: clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start_i  input  1  request to begin a divide; accepted only in IDLE.
REQ-005 SHALL have port: w_i  input  1  32-bit (*W) operation; operands sit in bits [31:0] with upper bits zero.
REQ-006 SHALL have port: X_i  input  64  unsigned dividend magnitude from the operand-conditioning stage.
REQ-007 SHALL have port: Y_i  input  64  unsigned divisor magnitude from the operand-conditioning stage.
REQ-008 SHALL have port: d_exception_i  input  1  divide-by-zero/overflow bypass flag from the conditioning stage.
REQ-009 SHALL have port: d_exception_result_i  input  64  final result to return when d_exception_i is set.
REQ-010 SHALL have port: flush_i  input  1  abort the current operation.
REQ-011 SHALL have port: busy_o  output  1  high in DIV and DONE states.
REQ-012 SHALL have port: done_o  output  1  single-cycle completion pulse.
REQ-013 SHALL have port: quotient_o  output  64  unsigned quotient.
REQ-014 SHALL have port: remainder_o  output  64  unsigned remainder.
REQ-015 SHALL have port: exc_o  output  1  result is the bypassed exception value.
REQ-016 SHALL have port: exc_result_o  output  64  latched d_exception_result_i.

Function
REQ-017 SHALL implement FSM states IDLE, DIV, DONE; reset state IDLE.
REQ-018 SHALL accept in IDLE when start_i=1 and flush_i=0 (acceptance edge = cycle 0), latching X_i, Y_i, w_i, d_exception_i, d_exception_result_i.
REQ-019 SHALL, on accepted start with d_exception_i=1, go to DONE directly: exc_o=1, exc_result_o=latched value, quotient_o=remainder_o=0, done_o high in cycle 1.
REQ-020 SHALL, on accepted start with d_exception_i=0, go to DIV with counter N=64 (w_i=0) or N=32 (w_i=1), remainder register R (65 bits) = 0, and Q = X_i (w_i=0) or {X_i[31:0], 32'b0} (w_i=1).
REQ-021 SHALL perform one restoring step per DIV cycle: T={R[63:0],Q[63]}-{1'b0,Y}; if T non-negative R=T and shift 1 into Q LSB, else R={R[63:0],Q[63]} and shift 0; decrement counter.
REQ-022 SHALL leave DIV for DONE after the step that brings the counter to 0, so done_o asserts in cycle N+1 (65 for 64-bit, 33 for *W).
REQ-023 SHALL drive quotient_o=Q and remainder_o=R[63:0] in DONE; for *W the upper 32 bits of both are zero.
REQ-024 SHALL pulse done_o for exactly one cycle (the DONE cycle), then return to IDLE.
REQ-025 SHALL hold quotient_o, remainder_o, exc_o, exc_result_o stable from DONE until the next accepted start.
REQ-026 SHALL ignore start_i while busy_o=1.
REQ-027 SHALL, on flush_i=1 in DIV or DONE, return to IDLE next edge with no done_o pulse; flush_i has priority over start_i in IDLE.
REQ-028 SHALL, when Y=0 reaches the datapath without d_exception_i, still complete in N cycles producing Q=all-ones (within width), R=X.
REQ-029 SHALL never produce X/Z on outputs after reset.

Reset
REQ-030 SHALL, on rst_i high at any time including mid-DIV, asynchronously force IDLE, busy_o=0, done_o=0, exc_o=0, and quotient_o, remainder_o, exc_result_o, counter, R, Q to 0.
REQ-031 SHALL accept a new start on the first rising edge after rst_i deasserts.

Verification
REQ-032 SHALL cover: X=100, Y=7, w=0 -> done_o at cycle 65, quotient_o=14, remainder_o=2, exc_o=0.
REQ-033 SHALL cover: X=0xFFFFFFFF, Y=0x10, w=1 -> done_o at cycle 33, quotient_o=0x0FFFFFFF, remainder_o=0xF.
REQ-034 SHALL cover: d_exception_i=1, d_exception_result_i=0xFFFFFFFFFFFFFFFF -> done_o at cycle 1, exc_o=1, exc_result_o=all-ones.
REQ-035 SHALL cover: X=5, Y=9 -> quotient_o=0, remainder_o=5; and X=all-ones, Y=1 -> quotient_o=all-ones, remainder_o=0.
REQ-036 SHALL cover: start then flush_i at cycle 20 -> no done_o, busy_o=0 at cycle 21; repeated start_i at cycle 10 ignored.
REQ-037 SHALL cover: rst_i pulsed at cycle 30 of a divide -> all outputs 0 immediately, then new start X=100, Y=7 completes correctly.

Source files
------------

// File: rtl/md_div_seq.sv
// md_div_seq: sequential radix-2 restoring divider core.
// Takes unsigned magnitudes from an upstream operand-conditioning stage.
// Produces one quotient bit per cycle: 64 steps for full width, 32 for *W.
// An exception result that was computed upstream (divide-by-zero or
// overflow) skips the iteration and completes in a single cycle.

module md_div_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            w_i,
  input  logic [XLEN-1:0] X_i,
  input  logic [XLEN-1:0] Y_i,
  input  logic            d_exception_i,
  input  logic [XLEN-1:0] d_exception_result_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            exc_o,
  output logic [XLEN-1:0] exc_result_o
);

  localparam int CW   = $clog2(XLEN) + 1;
  localparam int HALF = XLEN / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN:0]   r_rem;   // partial remainder R; bit XLEN only matters mid-step
  logic [XLEN-1:0] r_quo;   // dividend bits shift out of the top, quotient bits in at the bottom
  logic [XLEN-1:0] r_y;
  logic            r_w;
  logic [XLEN-1:0] r_exc_result;

  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_neg;
  logic [XLEN:0]   w_rem_next;
  logic [XLEN-1:0] w_quo_next;
  logic            w_last;
  logic [XLEN-1:0] w_mask;

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  // The extra difference bit is the borrow, so a set top bit means "restore".
  assign w_shift    = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_y};
  assign w_neg      = w_diff[XLEN+1];
  assign w_rem_next = w_neg ? w_shift : w_diff[XLEN:0];
  assign w_quo_next = {r_quo[XLEN-2:0], ~w_neg};
  assign w_last     = (r_cnt == CW'(1));

  // *W results keep their upper half cleared even if the operands were not.
  assign w_mask = {{HALF{~r_w}}, {HALF{1'b1}}};

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_y          <= '0;
      r_w          <= 1'b0;
      r_exc_result <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      quotient_o   <= '0;
      remainder_o  <= '0;
      exc_o        <= 1'b0;
      exc_result_o <= '0;
    end else begin
      // NOTE: every register here uses <= so all updates see pre-edge values;
      // a blocking = would let later statements read already-updated state.
      case (r_state)
        IDLE: begin
          done_o <= 1'b0;
          // flush_i wins over start_i so an aborted pipeline cannot launch work.
          if (start_i && !flush_i) begin
            r_w          <= w_i;
            r_y          <= Y_i;
            r_exc_result <= d_exception_result_i;
            busy_o       <= 1'b1;
            if (d_exception_i) begin
              r_state      <= DONE;
              done_o       <= 1'b1;
              exc_o        <= 1'b1;
              exc_result_o <= d_exception_result_i;
              quotient_o   <= '0;
              remainder_o  <= '0;
            end else begin
              r_state <= DIV;
              r_cnt   <= w_i ? CW'(HALF) : CW'(XLEN);
              r_rem   <= '0;
              // *W operands are pre-aligned to the top so only 32 steps are needed.
              r_quo   <= w_i ? {X_i[HALF-1:0], {HALF{1'b0}}} : X_i;
            end
          end
        end

        DIV: begin
          if (flush_i) begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
              r_state      <= DONE;
              done_o       <= 1'b1;
              quotient_o   <= w_quo_next & w_mask;
              remainder_o  <= w_rem_next[XLEN-1:0] & w_mask;
              exc_o        <= 1'b0;
              exc_result_o <= r_exc_result;
            end
          end
        end

        DONE: begin
          // Results stay in the output registers until the next accepted start.
          r_state <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
